// File: rtl/car_light_pkg.sv
// Shared encodings for the tail-lamp sequencing controller.
// State and mode codes are identical, so the state register drives mode.
package car_light_pkg;

   localparam logic [1:0] MODE_STRAIGHT = 2'b00;
   localparam logic [1:0] MODE_LEFT     = 2'b01;
   localparam logic [1:0] MODE_RIGHT    = 2'b10;
   localparam logic [1:0] MODE_HAZARD   = 2'b11;

   localparam logic LAMP_ON  = 1'b1;
   localparam logic LAMP_OFF = 1'b0;

endpackage

// File: rtl/car_debounce.sv
// Two-flop synchronizer followed by a stability counter.
// The output follows the input only after DEB_CYCLES unbroken cycles of disagreement.
module car_debounce #(
   parameter int DEB_CYCLES = 120000
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= 2'b00;
         cnt  <= '0;
         dout <= 1'b0;
      end else begin
         sync <= {sync[0], din};
         if (sync[1] == dout) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            dout <= sync[1];
            cnt  <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/car_light_ctrl.sv
// Turn/hazard sequencer for the tail-lamp pair with minimum blink count.
// Lamps are registered from next-state values so they change with mode.
module car_light_ctrl
   import car_light_pkg::*;
#(
   parameter int SLOW_HALF  = 6000000,
   parameter int FAST_HALF  = 1500000,
   parameter int DEB_CYCLES = 120000,
   parameter int MIN_BLINKS = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_left,
   input  logic       req_right,
   input  logic       req_hazard,
   input  logic       brake,
   output logic       lamp_left,
   output logic       lamp_right,
   output logic [1:0] mode
);

   localparam int MAX_HALF = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
   localparam int PW = (MAX_HALF > 1) ? $clog2(MAX_HALF) : 1;
   localparam int BW = (MIN_BLINKS > 0) ? $clog2(MIN_BLINKS + 1) : 1;

   localparam logic [PW-1:0] SLOW_LAST = PW'(SLOW_HALF - 1);
   localparam logic [PW-1:0] FAST_LAST = PW'(FAST_HALF - 1);
   localparam logic [BW-1:0] BLINK_MIN = BW'(MIN_BLINKS);

   logic          dl, dr, dh;
   logic [1:0]    brake_sync;
   logic          brk;
   logic          haz;

   logic [1:0]    state, nxt_state;
   logic          phase, nxt_phase;
   logic [PW-1:0] pcnt, nxt_pcnt;
   logic [BW-1:0] bcnt, nxt_bcnt;
   logic          min_done;
   logic          toggle;
   logic [PW-1:0] half_last;
   logic          nxt_lamp_l, nxt_lamp_r;

   car_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left (
      .clk  (clk),
      .rst  (rst),
      .din  (req_left),
      .dout (dl)
   );

   car_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (
      .clk  (clk),
      .rst  (rst),
      .din  (req_right),
      .dout (dr)
   );

   car_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_hazard (
      .clk  (clk),
      .rst  (rst),
      .din  (req_hazard),
      .dout (dh)
   );

   // Brake must react fast, so it is synchronized but never debounced.
   always_ff @(posedge clk) begin
      if (rst) begin
         brake_sync <= 2'b00;
      end else begin
         brake_sync <= {brake_sync[0], brake};
      end
   end

   assign brk      = brake_sync[1];
   assign haz      = dh | (dl & dr);
   assign min_done = (bcnt >= BLINK_MIN);

   always_comb begin
      nxt_state = state;
      unique case (state)
         MODE_STRAIGHT: begin
            if (haz)     nxt_state = MODE_HAZARD;
            else if (dl) nxt_state = MODE_LEFT;
            else if (dr) nxt_state = MODE_RIGHT;
         end
         MODE_LEFT: begin
            if (haz) nxt_state = MODE_HAZARD;
            else if (!dl && min_done)
               nxt_state = dr ? MODE_RIGHT : MODE_STRAIGHT;
         end
         MODE_RIGHT: begin
            if (haz) nxt_state = MODE_HAZARD;
            else if (!dr && min_done)
               nxt_state = dl ? MODE_LEFT : MODE_STRAIGHT;
         end
         MODE_HAZARD: begin
            if (!haz) nxt_state = MODE_STRAIGHT;
         end
      endcase
   end

   assign half_last = (state == MODE_HAZARD) ? FAST_LAST : SLOW_LAST;
   assign toggle    = (state != MODE_STRAIGHT) && (pcnt == half_last);

   // A state change overrides a coincident toggle and restarts the blink ON.
   always_comb begin
      nxt_phase = phase;
      nxt_pcnt  = pcnt;
      nxt_bcnt  = bcnt;
      if (nxt_state != state) begin
         nxt_phase = LAMP_ON;
         nxt_pcnt  = '0;
         nxt_bcnt  = '0;
      end else if (state == MODE_STRAIGHT) begin
         nxt_pcnt = '0;
      end else if (toggle) begin
         nxt_pcnt  = '0;
         nxt_phase = ~phase;
         if (phase == LAMP_ON && !min_done)
            nxt_bcnt = bcnt + 1'b1;
      end else begin
         nxt_pcnt = pcnt + 1'b1;
      end
   end

   always_comb begin
      nxt_lamp_l = brk;
      nxt_lamp_r = brk;
      unique case (nxt_state)
         MODE_STRAIGHT: begin
            nxt_lamp_l = brk;
            nxt_lamp_r = brk;
         end
         MODE_LEFT: begin
            nxt_lamp_l = nxt_phase;
            nxt_lamp_r = brk;
         end
         MODE_RIGHT: begin
            nxt_lamp_l = brk;
            nxt_lamp_r = nxt_phase;
         end
         MODE_HAZARD: begin
            nxt_lamp_l = nxt_phase;
            nxt_lamp_r = nxt_phase;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= MODE_STRAIGHT;
         phase      <= LAMP_OFF;
         pcnt       <= '0;
         bcnt       <= '0;
         lamp_left  <= LAMP_OFF;
         lamp_right <= LAMP_OFF;
      end else begin
         state      <= nxt_state;
         phase      <= nxt_phase;
         pcnt       <= nxt_pcnt;
         bcnt       <= nxt_bcnt;
         lamp_left  <= nxt_lamp_l;
         lamp_right <= nxt_lamp_r;
      end
   end

   assign mode = state;

endmodule

// File: tb/tb_car_light_ctrl.sv
// Directed bench for car_light_ctrl with short blink/debounce timing.
// Outputs are sampled 1 time unit after each rising edge.
module tb_car_light_ctrl;

   logic       clk;
   logic       rst;
   logic       req_left;
   logic       req_right;
   logic       req_hazard;
   logic       brake;
   logic       lamp_left;
   logic       lamp_right;
   logic [1:0] mode;

   int n_chk;
   int n_fail;

   car_light_ctrl #(
      .SLOW_HALF  (8),
      .FAST_HALF  (2),
      .DEB_CYCLES (4),
      .MIN_BLINKS (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_left   (req_left),
      .req_right  (req_right),
      .req_hazard (req_hazard),
      .brake      (brake),
      .lamp_left  (lamp_left),
      .lamp_right (lamp_right),
      .mode       (mode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_eq(input string tag, input logic [7:0] got,
                            input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [1:0] m,
                             input logic ll, input logic lr);
      expect_eq({tag, "_mode"}, {6'd0, mode}, {6'd0, m});
      expect_eq({tag, "_ll"}, {7'd0, lamp_left}, {7'd0, ll});
      expect_eq({tag, "_lr"}, {7'd0, lamp_right}, {7'd0, lr});
   endtask

   initial begin
      n_chk      = 0;
      n_fail     = 0;
      rst        = 1'b1;
      req_left   = 1'b0;
      req_right  = 1'b0;
      req_hazard = 1'b0;
      brake      = 1'b0;
      step(2);
      expect_out("reset", 2'b00, 1'b0, 1'b0);
      rst = 1'b0;
      step(3);

      // left turn entry and blink period
      req_left = 1'b1;
      step(6);
      expect_out("left_pre", 2'b00, 1'b0, 1'b0);
      step(1);
      expect_out("left_in", 2'b01, 1'b1, 1'b0);
      step(7);
      expect_out("left_on_end", 2'b01, 1'b1, 1'b0);
      step(1);
      expect_out("left_off", 2'b01, 1'b0, 1'b0);
      step(2);
      req_left = 1'b0;
      step(6);
      expect_out("left_on2", 2'b01, 1'b1, 1'b0);
      step(24);
      expect_out("left_min_hold", 2'b01, 1'b0, 1'b0);
      step(1);
      expect_out("left_exit", 2'b00, 1'b0, 1'b0);
      step(4);

      // bouncing switch never gets through
      for (int i = 0; i < 40; i++) begin
         req_left = (((i / 3) % 2) == 0);
         step(1);
         expect_eq("bounce_mode", {6'd0, mode}, 8'd0);
      end
      req_left = 1'b0;
      step(8);
      expect_out("bounce_end", 2'b00, 1'b0, 1'b0);

      // hazard preempts left at blink_cnt = 1
      req_left = 1'b1;
      step(7);
      expect_out("l2_in", 2'b01, 1'b1, 1'b0);
      step(8);
      expect_out("l2_off", 2'b01, 1'b0, 1'b0);
      step(1);
      req_hazard = 1'b1;
      req_left   = 1'b0;
      step(6);
      expect_eq("haz_pre", {6'd0, mode}, 8'd1);
      step(1);
      expect_out("haz_in", 2'b11, 1'b1, 1'b1);
      step(1);
      expect_out("haz_on2", 2'b11, 1'b1, 1'b1);
      step(1);
      expect_out("haz_off", 2'b11, 1'b0, 1'b0);
      step(2);
      expect_out("haz_on", 2'b11, 1'b1, 1'b1);
      req_hazard = 1'b0;
      step(6);
      expect_eq("haz_hold", {6'd0, mode}, 8'd3);
      step(2);
      expect_out("haz_exit", 2'b00, 1'b0, 1'b0);
      step(4);

      // brake in straight, then during right turn
      brake = 1'b1;
      step(2);
      expect_out("brk_lat2", 2'b00, 1'b0, 1'b0);
      step(1);
      expect_out("brk_lat3", 2'b00, 1'b1, 1'b1);
      req_right = 1'b1;
      step(7);
      expect_out("right_in", 2'b10, 1'b1, 1'b1);
      step(8);
      expect_out("right_off", 2'b10, 1'b1, 1'b0);
      req_right = 1'b0;
      step(32);
      expect_out("right_hold", 2'b10, 1'b1, 1'b0);
      step(1);
      expect_out("right_exit", 2'b00, 1'b1, 1'b1);

      // hazard ignores brake, then reset mid-blink
      req_hazard = 1'b1;
      step(7);
      expect_out("hb_in", 2'b11, 1'b1, 1'b1);
      step(2);
      expect_out("hb_off", 2'b11, 1'b0, 1'b0);
      step(1);
      rst = 1'b1;
      step(1);
      expect_out("rst_mid", 2'b00, 1'b0, 1'b0);
      rst = 1'b0;
      step(1);
      expect_out("rst_p1", 2'b00, 1'b0, 1'b0);
      step(2);
      expect_out("rst_p3", 2'b00, 1'b1, 1'b1);
      step(3);
      expect_eq("rst_deb6", {6'd0, mode}, 8'd0);
      step(1);
      expect_out("rst_deb7", 2'b11, 1'b1, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
